// File: rtl/phase_code_sequencer.sv
// Serialises a latched phase code onto out, one chip per tiempo_b clocks, on each sinc rising edge; out/busy
// respond one clock after the start edge. No backpressure: sinc low aborts a run, and HOLD blocks retrigger within a window.
module phase_code_sequencer #(
  parameter int CODE_W = 64,
  parameter int CNT_W  = 32,
  parameter int REP_W  = 8,
  localparam int IDX_W = $clog2(CODE_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sinc,
  input  logic [IDX_W-1:0]  num_dig,
  input  logic [CODE_W-1:0] codigo,
  input  logic [CNT_W-1:0]  tiempo_b,
  input  logic [REP_W-1:0]  n_rep,
  input  logic              msb_first,
  output logic              out,
  output logic              busy,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t            state, state_n;
  logic              sinc_q, armed, start, cfg_ok, load;
  logic [CODE_W-1:0] code_l;
  logic [IDX_W-1:0]  num_l;
  logic [CNT_W-1:0]  tb_l;
  logic [REP_W-1:0]  rep_l;
  logic              msb_l;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  pos, pos_n, idx_n;
  logic [REP_W-1:0]  rep_cnt, rep_n;
  logic              out_n, busy_n, done_n, err_n;

  function automatic logic chip_at(input logic [CODE_W-1:0] code, input logic [IDX_W-1:0] n,
                                   input logic [IDX_W-1:0] p, input logic m);
    logic [IDX_W-1:0]  idx;
    logic [CODE_W-1:0] sh;
    idx = m ? (n - p - IDX_W'(1)) : p;
    sh  = code >> idx;
    return sh[0];
  endfunction

  // armed blocks a start from a sinc that was already high when reset released
  assign start  = sinc & ~sinc_q & armed;
  assign cfg_ok = (num_dig != '0) && (num_dig <= IDX_W'(CODE_W)) && (tiempo_b != '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pos_n   = pos;
    rep_n   = rep_cnt;
    out_n   = 1'b0;
    busy_n  = 1'b0;
    idx_n   = '0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            load    = 1'b1;
            state_n = RUN;
            out_n   = chip_at(codigo, num_dig, '0, msb_first);
            busy_n  = 1'b1;
            cnt_n   = '0;
            pos_n   = '0;
            rep_n   = '0;
          end else begin
            err_n   = 1'b1;
            state_n = HOLD;
          end
        end
      end
      RUN: begin
        if (!sinc) begin
          state_n = IDLE;
        end else if (cnt == tb_l - CNT_W'(1)) begin
          cnt_n = '0;
          if (pos == num_l - IDX_W'(1)) begin
            if (rep_cnt == rep_l - REP_W'(1)) begin
              done_n  = 1'b1;
              state_n = HOLD;
            end else begin
              rep_n  = rep_cnt + REP_W'(1);
              pos_n  = '0;
              busy_n = 1'b1;
              out_n  = chip_at(code_l, num_l, '0, msb_l);
            end
          end else begin
            pos_n  = pos + IDX_W'(1);
            idx_n  = pos + IDX_W'(1);
            busy_n = 1'b1;
            out_n  = chip_at(code_l, num_l, pos + IDX_W'(1), msb_l);
          end
        end else begin
          cnt_n  = cnt + CNT_W'(1);
          busy_n = 1'b1;
          out_n  = out;
          idx_n  = bit_idx;
        end
      end
      HOLD: begin
        if (!sinc) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sinc_q  <= 1'b0;
      armed   <= 1'b0;
      code_l  <= '0;
      num_l   <= '0;
      tb_l    <= '0;
      rep_l   <= '0;
      msb_l   <= 1'b0;
      cnt     <= '0;
      pos     <= '0;
      rep_cnt <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
      bit_idx <= '0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_n;
      sinc_q  <= sinc;
      armed   <= armed | ~sinc;
      cnt     <= cnt_n;
      pos     <= pos_n;
      rep_cnt <= rep_n;
      out     <= out_n;
      busy    <= busy_n;
      bit_idx <= idx_n;
      done    <= done_n;
      cfg_err <= err_n;
      if (load) begin
        code_l <= codigo;
        num_l  <= num_dig;
        tb_l   <= tiempo_b;
        rep_l  <= (n_rep == '0) ? REP_W'(1) : n_rep;
        msb_l  <= msb_first;
      end
    end
  end

endmodule
